// File: rtl/majority_resp_checker_if.sv
// majority_resp_checker_if: stimulus/response bundle between a majority stream source and its checker
// Signals: start, a, a_valid, d (source -> checker); err_cnt, cov, fail_seen, fail_vec, mismatch, done, pass (checker -> source)
interface majority_resp_checker_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [2:0]       a;
    logic             a_valid;
    logic             d;
    logic [CNT_W-1:0] err_cnt;
    logic [7:0]       cov;
    logic             fail_seen;
    logic [2:0]       fail_vec;
    logic             mismatch;
    logic             done;
    logic             pass;
    modport master (
        output start, a, a_valid, d,
        input  err_cnt, cov, fail_seen, fail_vec, mismatch, done, pass
    );
    modport slave (
        input  start, a, a_valid, d,
        output err_cnt, cov, fail_seen, fail_vec, mismatch, done, pass
    );
endinterface

// File: rtl/majority_resp_checker.sv
// majority_resp_checker: checks a 3-input majority DUT's responses LAT cycles after each applied vector
// Ports: clk, rst_n (async active-low), bus (slave: start/a/a_valid/d in; err_cnt/cov/fail_seen/fail_vec/mismatch/done/pass out)
module majority_resp_checker #(
    parameter int LAT   = 1,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    majority_resp_checker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           r_state, w_next;
    logic [LAT-1:0]   r_v, r_e;
    logic [2:0]       r_a [LAT];
    logic [CNT_W-1:0] r_err;
    logic [7:0]       r_cov;
    logic             r_fail, r_mis;
    logic [2:0]       r_fvec;
    logic             w_exp, w_push, w_chk, w_mis;
    assign w_exp  = (bus.a[0] & bus.a[1]) | (bus.a[0] & bus.a[2]) | (bus.a[1] & bus.a[2]);
    assign w_push = (r_state == RUN) && bus.a_valid;
    assign w_chk  = r_v[LAT-1];
    assign w_mis  = w_chk && (bus.d != r_e[LAT-1]);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    always_comb begin
        w_next = r_state;
        if (bus.start) w_next = RUN;
        else if (r_state == RUN && r_cov == 8'hFF && r_v == '0) w_next = DONE;
    end
    // start outranks everything: in-flight entries are dropped and a same-cycle a_valid is not pushed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v    <= '0;
            r_e    <= '0;
            for (int i = 0; i < LAT; i++) r_a[i] <= '0;
            r_err  <= '0;
            r_cov  <= '0;
            r_fail <= 1'b0;
            r_fvec <= '0;
            r_mis  <= 1'b0;
        end else if (bus.start) begin
            r_v    <= '0;
            r_err  <= '0;
            r_cov  <= '0;
            r_fail <= 1'b0;
            r_fvec <= '0;
            r_mis  <= 1'b0;
        end else begin
            r_v[0] <= w_push;
            r_e[0] <= w_exp;
            r_a[0] <= bus.a;
            for (int i = 1; i < LAT; i++) begin
                r_v[i] <= r_v[i-1];
                r_e[i] <= r_e[i-1];
                r_a[i] <= r_a[i-1];
            end
            r_mis <= w_mis;
            if (w_chk) r_cov <= r_cov | (8'd1 << r_a[LAT-1]);
            if (w_mis && r_err != '1) r_err <= r_err + 1'b1;
            if (w_mis && !r_fail) begin
                r_fail <= 1'b1;
                r_fvec <= r_a[LAT-1];
            end
        end
    end
    assign bus.err_cnt   = r_err;
    assign bus.cov       = r_cov;
    assign bus.fail_seen = r_fail;
    assign bus.fail_vec  = r_fvec;
    assign bus.mismatch  = r_mis;
    assign bus.done      = (r_state == DONE);
    assign bus.pass      = (r_state == DONE) && (r_err == '0);
endmodule

// File: tb/tb_majority_resp_checker.sv
// tb_majority_resp_checker: directed checks of the majority response checker at several latencies and counter widths
module tb_majority_resp_checker;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       a_valid = 1'b0;
    logic [2:0] a = 3'd0;
    logic       tab_d = 1'b0;
    logic       use_tab = 1'b1;
    int         mode = 0;
    int         checks = 0;
    int         errors = 0;
    int         cnt3 = 0, cnt4 = 0, cnts = 0;
    logic [7:0] mask3 = 8'd0;
    logic [2:0] hist [9];

    always #5 clk = ~clk;

    majority_resp_checker_if #(.CNT_W(8)) f1 ();
    majority_resp_checker_if #(.CNT_W(8)) f3 ();
    majority_resp_checker_if #(.CNT_W(8)) f4 ();
    majority_resp_checker_if #(.CNT_W(2)) fs ();

    majority_resp_checker #(.LAT(1), .CNT_W(8)) u1 (.clk(clk), .rst_n(rst_n), .bus(f1));
    majority_resp_checker #(.LAT(3), .CNT_W(8)) u3 (.clk(clk), .rst_n(rst_n), .bus(f3));
    majority_resp_checker #(.LAT(4), .CNT_W(8)) u4 (.clk(clk), .rst_n(rst_n), .bus(f4));
    majority_resp_checker #(.LAT(2), .CNT_W(2)) us (.clk(clk), .rst_n(rst_n), .bus(fs));

    // Reference majority and the fault modes of the modelled DUT
    function automatic logic dut_resp(input logic [2:0] x, input int m);
        logic maj;
        maj = ($countones(x) >= 2);
        return (m == 0) ? maj : (m == 1) ? 1'b0 : !maj;
    endfunction

    // hist[n] holds a as sampled n+1 edges ago, so a DUT of latency L answers from hist[L-1]
    always_ff @(posedge clk) begin
        hist[0] <= a;
        for (int i = 1; i < 9; i++) hist[i] <= hist[i-1];
    end

    assign f1.start = start;  assign f1.a = a;  assign f1.a_valid = a_valid;
    assign f3.start = start;  assign f3.a = a;  assign f3.a_valid = a_valid;
    assign f4.start = start;  assign f4.a = a;  assign f4.a_valid = a_valid;
    assign fs.start = start;  assign fs.a = a;  assign fs.a_valid = a_valid;
    assign f1.d = use_tab ? tab_d : dut_resp(hist[0], mode);
    assign fs.d = dut_resp(hist[1], mode);
    assign f3.d = dut_resp(hist[2], mode);
    assign f4.d = dut_resp(hist[3], mode);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic st, input logic av, input logic [2:0] v);
        start = st;
        a_valid = av;
        a = v;
        @(posedge clk);
        #1;
        if (f3.mismatch) begin
            cnt3++;
            mask3 = mask3 | (8'd1 << hist[3]);
        end
        if (f4.mismatch) cnt4++;
        if (fs.mismatch) cnts++;
    endtask

    typedef struct {
        logic       st, av;
        logic [2:0] a;
        logic       d;
        logic [7:0] err, cov;
        logic       mis, fs;
        logic [2:0] fv;
        logic       dn, ps;
    } vec_t;
    vec_t tab [16];

    initial begin
        //            st  av  a  d   err   cov    mis fs fv dn ps
        tab[0]  = '{1'b1,1'b0,3'd0,1'b0,8'd0,8'h00,1'b0,1'b0,3'd0,1'b0,1'b0};
        tab[1]  = '{1'b0,1'b1,3'd0,1'b0,8'd0,8'h00,1'b0,1'b0,3'd0,1'b0,1'b0};
        tab[2]  = '{1'b0,1'b1,3'd1,1'b0,8'd0,8'h01,1'b0,1'b0,3'd0,1'b0,1'b0};
        tab[3]  = '{1'b0,1'b1,3'd2,1'b0,8'd0,8'h03,1'b0,1'b0,3'd0,1'b0,1'b0};
        tab[4]  = '{1'b0,1'b1,3'd3,1'b0,8'd0,8'h07,1'b0,1'b0,3'd0,1'b0,1'b0};
        tab[5]  = '{1'b0,1'b1,3'd4,1'b1,8'd0,8'h0F,1'b0,1'b0,3'd0,1'b0,1'b0};
        tab[6]  = '{1'b0,1'b1,3'd5,1'b0,8'd0,8'h1F,1'b0,1'b0,3'd0,1'b0,1'b0};
        tab[7]  = '{1'b0,1'b1,3'd6,1'b1,8'd0,8'h3F,1'b0,1'b0,3'd0,1'b0,1'b0};
        tab[8]  = '{1'b0,1'b1,3'd7,1'b1,8'd0,8'h7F,1'b0,1'b0,3'd0,1'b0,1'b0};
        tab[9]  = '{1'b0,1'b0,3'd0,1'b1,8'd0,8'hFF,1'b0,1'b0,3'd0,1'b0,1'b0};
        tab[10] = '{1'b0,1'b0,3'd0,1'b0,8'd0,8'hFF,1'b0,1'b0,3'd0,1'b1,1'b1};
        tab[11] = '{1'b1,1'b1,3'd3,1'b0,8'd0,8'h00,1'b0,1'b0,3'd0,1'b0,1'b0};
        tab[12] = '{1'b0,1'b1,3'd5,1'b0,8'd0,8'h00,1'b0,1'b0,3'd0,1'b0,1'b0};
        tab[13] = '{1'b0,1'b1,3'd2,1'b0,8'd1,8'h20,1'b1,1'b1,3'd5,1'b0,1'b0};
        tab[14] = '{1'b0,1'b0,3'd0,1'b1,8'd2,8'h24,1'b1,1'b1,3'd5,1'b0,1'b0};
        tab[15] = '{1'b0,1'b0,3'd0,1'b0,8'd2,8'h24,1'b0,1'b1,3'd5,1'b0,1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset err_cnt", int'(f1.err_cnt), 0);
        chk("reset cov", int'(f1.cov), 0);
        chk("reset done", int'(f1.done), 0);
        chk("reset pass", int'(f3.pass), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            start = tab[i].st;
            a_valid = tab[i].av;
            a = tab[i].a;
            tab_d = tab[i].d;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d err_cnt", i), int'(f1.err_cnt), int'(tab[i].err));
            chk($sformatf("row%0d cov", i), int'(f1.cov), int'(tab[i].cov));
            chk($sformatf("row%0d mismatch", i), int'(f1.mismatch), int'(tab[i].mis));
            chk($sformatf("row%0d fail_seen", i), int'(f1.fail_seen), int'(tab[i].fs));
            chk($sformatf("row%0d fail_vec", i), int'(f1.fail_vec), int'(tab[i].fv));
            chk($sformatf("row%0d done", i), int'(f1.done), int'(tab[i].dn));
            chk($sformatf("row%0d pass", i), int'(f1.pass), int'(tab[i].ps));
        end
        use_tab = 1'b0;

        mode = 2;
        cyc(1'b1, 1'b0, 3'd0);
        repeat (3) cyc(1'b0, 1'b1, 3'd7);
        chk("prereset err_cnt", int'(f1.err_cnt), 2);
        chk("prereset mismatch", int'(f1.mismatch), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async err_cnt", int'(f1.err_cnt), 0);
        chk("async cov", int'(f1.cov), 0);
        chk("async fail_seen", int'(f1.fail_seen), 0);
        chk("async fail_vec", int'(f1.fail_vec), 0);
        chk("async mismatch", int'(f1.mismatch), 0);
        #1 rst_n = 1'b1;
        repeat (4) cyc(1'b0, 1'b1, 3'd3);
        chk("idle err_cnt", int'(f1.err_cnt), 0);
        chk("idle cov", int'(f1.cov), 0);
        chk("idle done", int'(f1.done), 0);

        mode = 1;
        cnt3 = 0;
        mask3 = 8'd0;
        cyc(1'b1, 1'b0, 3'd0);
        for (int v = 0; v < 8; v++) cyc(1'b0, 1'b1, 3'(v));
        repeat (6) cyc(1'b0, 1'b0, 3'd0);
        chk("stuck err_cnt", int'(f3.err_cnt), 4);
        chk("stuck pulses", cnt3, 4);
        chk("stuck pulse vectors", int'(mask3), 8'hE8);
        chk("stuck fail_vec", int'(f3.fail_vec), 3);
        chk("stuck fail_seen", int'(f3.fail_seen), 1);
        chk("stuck cov", int'(f3.cov), 8'hFF);
        chk("stuck done", int'(f3.done), 1);
        chk("stuck pass", int'(f3.pass), 0);

        mode = 0;
        cyc(1'b1, 1'b0, 3'd0);
        repeat (3) cyc(1'b0, 1'b1, 3'd7);
        for (int v = 0; v < 6; v++) begin
            cyc(1'b0, 1'b1, 3'(v));
            cyc(1'b0, 1'b0, 3'd0);
        end
        chk("bubble cov before 6", int'(f1.cov), 8'hBF);
        chk("bubble done before 6", int'(f1.done), 0);
        cyc(1'b0, 1'b1, 3'd6);
        chk("bubble cov 6 pending", int'(f1.cov), 8'hBF);
        cyc(1'b0, 1'b0, 3'd0);
        chk("bubble cov full", int'(f1.cov), 8'hFF);
        chk("bubble done lag", int'(f1.done), 0);
        cyc(1'b0, 1'b0, 3'd0);
        chk("bubble err_cnt", int'(f1.err_cnt), 0);
        chk("bubble done", int'(f1.done), 1);
        chk("bubble pass", int'(f1.pass), 1);

        mode = 2;
        cnts = 0;
        cyc(1'b1, 1'b0, 3'd0);
        for (int v = 0; v < 8; v++) cyc(1'b0, 1'b1, 3'(v));
        repeat (5) cyc(1'b0, 1'b0, 3'd0);
        chk("sat err_cnt", int'(fs.err_cnt), 3);
        chk("sat pulses", cnts, 8);
        chk("sat fail_vec", int'(fs.fail_vec), 0);
        chk("sat fail_seen", int'(fs.fail_seen), 1);
        chk("sat done", int'(fs.done), 1);
        chk("sat pass", int'(fs.pass), 0);

        mode = 3;
        cnt4 = 0;
        cyc(1'b1, 1'b0, 3'd0);
        cyc(1'b0, 1'b1, 3'd5);
        cyc(1'b0, 1'b1, 3'd2);
        cyc(1'b1, 1'b0, 3'd0);
        repeat (6) cyc(1'b0, 1'b0, 3'd0);
        chk("restart pulses", cnt4, 0);
        chk("restart err_cnt", int'(f4.err_cnt), 0);
        chk("restart cov", int'(f4.cov), 0);
        chk("restart done", int'(f4.done), 0);
        mode = 0;
        for (int v = 0; v < 8; v++) cyc(1'b0, 1'b1, 3'(v));
        repeat (6) cyc(1'b0, 1'b0, 3'd0);
        chk("resweep err_cnt", int'(f4.err_cnt), 0);
        chk("resweep cov", int'(f4.cov), 8'hFF);
        chk("resweep done", int'(f4.done), 1);
        chk("resweep pass", int'(f4.pass), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
